// File: rtl/cpu_instr_feeder_if.sv
// Host-side push channel into the instruction feeder FIFO.
// The host drives word/valid; the feeder answers with ready.
interface cpu_instr_feeder_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_code;
    logic [11:0] in_immd;
    logic        in_has_immd;

    modport master (
        output in_valid,
        output in_code,
        output in_immd,
        output in_has_immd,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_code,
        input  in_immd,
        input  in_has_immd,
        output in_ready
    );
endinterface

// File: rtl/cpu_instr_feeder.sv
// Buffers host instruction words in a FIFO and replays them onto the CPU load port.
// Define FEEDER_STATUS_EN to add the issued_cnt / ovf status ports.
module cpu_instr_feeder #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned WE_CYCLES  = 1,
    parameter int unsigned IMMD_HOLD  = 2,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned EN_SETUP   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    cpu_instr_feeder_if.slave        host,
    input  logic                     flush,
    output logic                     en,
    output logic                     we_IM,
    output logic [15:0]              codein,
    output logic [11:0]              immd,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
`ifdef FEEDER_STATUS_EN
    ,
    output logic [15:0]              issued_cnt,
    output logic                     ovf
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {StIdle, StSetup, StWrite, StImmd, StGap} state_e;

    logic [15:0]   mem_code [DEPTH];
    logic [11:0]   mem_immd [DEPTH];
    logic          mem_has  [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    state_e        state_q;
    logic [31:0]   phase_q;
    logic [11:0]   immd_lat_q;
    logic          has_lat_q;
    logic          push;
    logic          pop;

    assign host.in_ready = (count_q < CW'(DEPTH)) && !flush && !rst;
    assign push          = host.in_valid && host.in_ready;
    // Pop only once the CPU has been enabled; the first word after idle goes via SETUP.
    assign pop           = (state_q == StIdle) && (count_q != '0) && en;
    assign busy          = (state_q != StIdle) || (count_q != '0);
    assign level         = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= StIdle;
            phase_q    <= '0;
            immd_lat_q <= '0;
            has_lat_q  <= 1'b0;
            en         <= 1'b0;
            we_IM      <= 1'b0;
            codein     <= '0;
            immd       <= '0;
`ifdef FEEDER_STATUS_EN
            issued_cnt <= '0;
            ovf        <= 1'b0;
`endif
        end else if (flush) begin
            // codein/immd deliberately keep their last values across a flush.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            phase_q  <= '0;
            en       <= 1'b0;
            we_IM    <= 1'b0;
        end else begin
`ifdef FEEDER_STATUS_EN
            if (host.in_valid && !host.in_ready) begin
                ovf <= 1'b1;
            end
`endif
            if (push) begin
                mem_code[wr_ptr_q] <= host.in_code;
                mem_immd[wr_ptr_q] <= host.in_immd;
                mem_has[wr_ptr_q]  <= host.in_has_immd;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (count_q != '0) begin
                        phase_q <= '0;
                        if (!en) begin
                            en      <= 1'b1;
                            state_q <= StSetup;
                        end else begin
                            codein     <= mem_code[rd_ptr_q];
                            immd_lat_q <= mem_immd[rd_ptr_q];
                            has_lat_q  <= mem_has[rd_ptr_q];
                            we_IM      <= 1'b1;
                            state_q    <= StWrite;
`ifdef FEEDER_STATUS_EN
                            issued_cnt <= issued_cnt + 16'd1;
`endif
                        end
                    end
                end
                StSetup: begin
                    if (phase_q == EN_SETUP - 1) begin
                        phase_q <= '0;
                        state_q <= StIdle;
                    end else begin
                        phase_q <= phase_q + 1;
                    end
                end
                StWrite: begin
                    if (phase_q == WE_CYCLES - 1) begin
                        we_IM   <= 1'b0;
                        phase_q <= '0;
                        if (has_lat_q) begin
                            immd    <= immd_lat_q;
                            state_q <= StImmd;
                        end else begin
                            state_q <= (GAP_CYCLES == 0) ? StIdle : StGap;
                        end
                    end else begin
                        phase_q <= phase_q + 1;
                    end
                end
                StImmd: begin
                    if (phase_q == IMMD_HOLD - 1) begin
                        phase_q <= '0;
                        state_q <= (GAP_CYCLES == 0) ? StIdle : StGap;
                    end else begin
                        phase_q <= phase_q + 1;
                    end
                end
                StGap: begin
                    if (phase_q == GAP_CYCLES - 1) begin
                        phase_q <= '0;
                        state_q <= StIdle;
                    end else begin
                        phase_q <= phase_q + 1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
